// File: rtl/fetch_pc_reg_if.sv
// Instruction-memory read handshake and decode handoff between the fetch sequencer and its neighbours.
// master = fetch sequencer side, slave = memory/decode side.
interface fetch_pc_reg_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// state | meaning
// IDLE  | leaving reset, fetch begins on next edge
// FETCH | imem_req held with imem_addr=old_PC until imem_ack
// ISSUE | instr_valid held until decode asserts instr_ready
// EXEC  | waiting for commit pulse pc_load carrying the next PC
// FAULT | misaligned PC committed; terminal until reset
module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   new_PC,
    input  logic          pc_load,
    output logic [31:0]   old_PC,
    output logic          fault,
    output logic [31:0]   instr_count,
    fetch_pc_reg_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        fault_q, fault_d;
    logic        load_ok, load_bad;

    assign load_ok  = (state_q == S_EXEC) && pc_load && (new_PC[1:0] == 2'b00);
    assign load_bad = (state_q == S_EXEC) && pc_load && (new_PC[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_count_q <= 32'h0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_count_q <= instr_count_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (bus.imem_ack)    state_d = S_ISSUE;
            S_ISSUE: if (bus.instr_ready) state_d = S_EXEC;
            S_EXEC: begin
                if (load_ok)       state_d = S_FETCH;
                else if (load_bad) state_d = S_FAULT;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d          = load_ok ? new_PC : pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q;
        fault_d       = fault_q | load_bad;
        if (state_q == S_FETCH && bus.imem_ack)
            instr_d = bus.imem_rdata;
        if (state_q == S_ISSUE && bus.instr_ready)
            instr_count_d = instr_count_q + 32'd1;
    end

    // Handshake outputs come from state alone so no input reaches them combinationally.
    always_comb begin
        bus.imem_req    = (state_q == S_FETCH);
        bus.instr_valid = (state_q == S_ISSUE);
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign old_PC        = pc_q;
    assign fault         = fault_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Directed bench for fetch_pc_reg: vector table for the main fetch/issue/exec loop plus hand sequences.
module tb_fetch_pc_reg;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] new_PC = 32'h0;
    logic        pc_load = 1'b0;
    logic [31:0] old_PC;
    logic        fault;
    logic [31:0] instr_count;
    int          checks = 0;
    int          errors = 0;

    fetch_pc_reg_if bus();

    fetch_pc_reg #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .new_PC      (new_PC),
        .pc_load     (pc_load),
        .old_PC      (old_PC),
        .fault       (fault),
        .instr_count (instr_count),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_load;
        logic [31:0] new_pc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic req,
                           input logic valid, input logic [31:0] ins, input logic flt,
                           input logic [31:0] cnt);
        chk({tag, " old_PC"}, old_PC, pc);
        chk({tag, " imem_addr"}, bus.imem_addr, pc);
        chk({tag, " imem_req"}, {31'b0, bus.imem_req}, {31'b0, req});
        chk({tag, " instr_valid"}, {31'b0, bus.instr_valid}, {31'b0, valid});
        chk({tag, " instr"}, bus.instr, ins);
        chk({tag, " fault"}, {31'b0, fault}, {31'b0, flt});
        chk({tag, " instr_count"}, instr_count, cnt);
    endtask

    task automatic drive(input logic ld, input logic [31:0] npc, input logic ack,
                         input logic [31:0] rd, input logic rdy);
        pc_load        = ld;
        new_PC         = npc;
        bus.imem_ack   = ack;
        bus.imem_rdata = rd;
        bus.instr_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pc_load new_pc ack rdata ready | pc req valid instr fault count
        vecs[0]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0, 1, 0, 32'h0,         0, 0};
        vecs[1]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0, 1, 0, 32'h0,         0, 0};
        vecs[2]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0, 1, 0, 32'h0,         0, 0};
        vecs[3]  = '{0, 32'h0,   1, 32'h2008_0005, 0, 32'h0, 0, 1, 32'h2008_0005, 0, 0};
        vecs[4]  = '{1, 32'h40,  0, 32'h0,         0, 32'h0, 0, 1, 32'h2008_0005, 0, 0};
        vecs[5]  = '{0, 32'h0,   1, 32'hDEAD_BEEF, 0, 32'h0, 0, 1, 32'h2008_0005, 0, 0};
        vecs[6]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0, 0, 1, 32'h2008_0005, 0, 0};
        vecs[7]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0, 0, 1, 32'h2008_0005, 0, 0};
        vecs[8]  = '{0, 32'h0,   0, 32'h0,         0, 32'h0, 0, 1, 32'h2008_0005, 0, 0};
        vecs[9]  = '{0, 32'h0,   0, 32'h0,         1, 32'h0, 0, 0, 32'h2008_0005, 0, 1};
        vecs[10] = '{0, 32'h0,   1, 32'hBAD0_BAD0, 1, 32'h0, 0, 0, 32'h2008_0005, 0, 1};
        vecs[11] = '{1, 32'h4,   0, 32'h0,         0, 32'h4, 1, 0, 32'h2008_0005, 0, 1};
        vecs[12] = '{1, 32'h80,  0, 32'h0,         0, 32'h4, 1, 0, 32'h2008_0005, 0, 1};
        vecs[13] = '{0, 32'h0,   1, 32'h1234_5678, 0, 32'h4, 0, 1, 32'h1234_5678, 0, 1};
        vecs[14] = '{0, 32'h0,   0, 32'h0,         1, 32'h4, 0, 0, 32'h1234_5678, 0, 2};
        vecs[15] = '{1, 32'h4,   0, 32'h0,         0, 32'h4, 1, 0, 32'h1234_5678, 0, 2};
        vecs[16] = '{0, 32'h0,   1, 32'hAABB_CCDD, 0, 32'h4, 0, 1, 32'hAABB_CCDD, 0, 2};
        vecs[17] = '{0, 32'h0,   0, 32'h0,         1, 32'h4, 0, 0, 32'hAABB_CCDD, 0, 3};
        vecs[18] = '{1, 32'h102, 0, 32'h0,         0, 32'h4, 0, 0, 32'hAABB_CCDD, 1, 3};
        vecs[19] = '{1, 32'h8,   1, 32'h5555_5555, 1, 32'h4, 0, 0, 32'hAABB_CCDD, 1, 3};
        vecs[20] = '{0, 32'h0,   0, 32'h0,         0, 32'h4, 0, 0, 32'hAABB_CCDD, 1, 3};

        drive(0, 32'h0, 0, 32'h0, 0);
        #2;
        chk_all("reset", 32'h0, 0, 0, 32'h0, 0, 32'h0);
        #10;
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].pc_load, vecs[i].new_pc, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_fault, vecs[i].e_count);
        end

        // Reset clears the sticky fault and returns PC to RESET_PC, asynchronously.
        drive(0, 32'h0, 0, 32'h0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("fault_reset", 32'h0, 0, 0, 32'h0, 0, 32'h0);
        #3;
        reset_n = 1'b1;
        tick();
        chk_all("refetch", 32'h0, 1, 0, 32'h0, 0, 32'h0);

        // Reset between edges while FETCH is outstanding; ack during reset has no effect.
        #2;
        reset_n = 1'b0;
        #1;
        chk({"midfetch imem_req"}, {31'b0, bus.imem_req}, 32'h0);
        drive(0, 32'h0, 1, 32'h7777_7777, 0);
        tick();
        chk_all("ack_in_reset", 32'h0, 0, 0, 32'h0, 0, 32'h0);
        drive(0, 32'h0, 0, 32'h0, 0);
        #2;
        reset_n = 1'b1;
        tick();
        chk_all("post_reset", 32'h0, 1, 0, 32'h0, 0, 32'h0);

        // Counter wrap: preload all-ones while parked in ISSUE, then hand off once more.
        drive(0, 32'h0, 1, 32'h0BAD_F00D, 0);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0);
        force dut.instr_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.instr_count_q;
        #1;
        chk_all("preload", 32'h0, 0, 1, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF);
        drive(0, 32'h0, 0, 32'h0, 1);
        tick();
        chk_all("wrap", 32'h0, 0, 0, 32'h0BAD_F00D, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
